// File: rtl/cp0_exc_ctrl_if.sv
// Bundle of the MEM-stage requests, current CP0 state and CP0 write-port /
// pipeline-control responses exchanged with the exception sequencer.
interface cp0_exc_ctrl_if;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic        in_delay_slot_i;
    logic        eret_i;
    logic        mtc0_we_i;
    logic [4:0]  mtc0_addr_i;
    logic [31:0] mtc0_data_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;

    logic        cp0_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_wdata_o;
    logic        stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;

    // Pipeline / CP0 register file side.
    modport master (
        output exc_valid_i, exc_code_i, exc_pc_i, in_delay_slot_i, eret_i,
        output mtc0_we_i, mtc0_addr_i, mtc0_data_i,
        output status_i, cause_i, epc_i,
        input  cp0_we_o, cp0_waddr_o, cp0_wdata_o,
        input  stall_o, flush_o, new_pc_o, busy_o
    );

    // Exception sequencer side.
    modport slave (
        input  exc_valid_i, exc_code_i, exc_pc_i, in_delay_slot_i, eret_i,
        input  mtc0_we_i, mtc0_addr_i, mtc0_data_i,
        input  status_i, cause_i, epc_i,
        output cp0_we_o, cp0_waddr_o, cp0_wdata_o,
        output stall_o, flush_o, new_pc_o, busy_o
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt/ERET sequencer: serialises EPC/Cause/Status updates
// over the single CP0 write port, holds the pipeline, then flushes with a redirect.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR      = 32'h0000_0020,
    parameter logic [4:0]  CP0_STATUS_ADDR = 5'd12,
    parameter logic [4:0]  CP0_CAUSE_ADDR  = 5'd13,
    parameter logic [4:0]  CP0_EPC_ADDR    = 5'd14
) (
    input  logic           clk,
    input  logic           rst,
    cp0_exc_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_STATUS,
        E_STATUS,
        REDIRECT
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic [4:0]  code_q;
    logic        bd_q;
    logic        eret_q;

    logic        int_pending;
    logic        take_exc;
    logic        take_eret;
    logic [31:0] epc_val;
    logic [4:0]  code_in;
    logic [31:0] cause_wdata;

    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;

    assign int_pending = (|(bus.cause_i[15:8] & bus.status_i[15:8]))
                         & bus.status_i[0] & ~bus.status_i[1];

    // Acceptance is gated by rst so nothing leaks onto the outputs while reset is held.
    assign take_exc  = rst && (state == IDLE) && (bus.exc_valid_i || int_pending);
    assign take_eret = rst && (state == IDLE) && !(bus.exc_valid_i || int_pending)
                       && bus.eret_i;

    assign epc_val = bus.in_delay_slot_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
    assign code_in = bus.exc_valid_i ? bus.exc_code_i : 5'd0;

    // A nested exception (EXL already set) must not disturb the original BD bit.
    always_comb begin
        cause_wdata      = cause_q;
        cause_wdata[6:2] = code_q;
        if (!status_q[1]) begin
            cause_wdata[31] = bd_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q <= 32'd0;
            cause_q  <= 32'd0;
            epc_q    <= 32'd0;
            code_q   <= 5'd0;
            bd_q     <= 1'b0;
            eret_q   <= 1'b0;
        end else if (take_exc) begin
            status_q <= bus.status_i;
            cause_q  <= bus.cause_i;
            epc_q    <= epc_val;
            code_q   <= code_in;
            bd_q     <= bus.in_delay_slot_i;
            eret_q   <= 1'b0;
        end else if (take_eret) begin
            status_q <= bus.status_i;
            epc_q    <= bus.epc_i;
            eret_q   <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cp0_we    = 1'b0;
        cp0_waddr = 5'd0;
        cp0_wdata = 32'd0;
        stall     = 1'b0;
        flush     = 1'b0;
        new_pc    = 32'd0;
        busy      = 1'b0;

        case (state)
            IDLE: begin
                if (take_exc) begin
                    stall     = 1'b1;
                    state_nxt = bus.status_i[1] ? W_CAUSE : W_EPC;
                end else if (take_eret) begin
                    stall     = 1'b1;
                    state_nxt = E_STATUS;
                end else if (rst) begin
                    cp0_we    = bus.mtc0_we_i;
                    cp0_waddr = bus.mtc0_addr_i;
                    cp0_wdata = bus.mtc0_data_i;
                end
            end
            W_EPC: begin
                cp0_we    = 1'b1;
                cp0_waddr = CP0_EPC_ADDR;
                cp0_wdata = epc_q;
                stall     = 1'b1;
                busy      = 1'b1;
                state_nxt = W_CAUSE;
            end
            W_CAUSE: begin
                cp0_we    = 1'b1;
                cp0_waddr = CP0_CAUSE_ADDR;
                cp0_wdata = cause_wdata;
                stall     = 1'b1;
                busy      = 1'b1;
                state_nxt = W_STATUS;
            end
            W_STATUS: begin
                cp0_we    = 1'b1;
                cp0_waddr = CP0_STATUS_ADDR;
                cp0_wdata = status_q | 32'h0000_0002;
                stall     = 1'b1;
                busy      = 1'b1;
                state_nxt = REDIRECT;
            end
            E_STATUS: begin
                cp0_we    = 1'b1;
                cp0_waddr = CP0_STATUS_ADDR;
                cp0_wdata = status_q & ~32'h0000_0002;
                stall     = 1'b1;
                busy      = 1'b1;
                state_nxt = REDIRECT;
            end
            REDIRECT: begin
                flush     = 1'b1;
                new_pc    = eret_q ? epc_q : EXC_VECTOR;
                stall     = 1'b1;
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.cp0_we_o    = cp0_we;
    assign bus.cp0_waddr_o = cp0_waddr;
    assign bus.cp0_wdata_o = cp0_wdata;
    assign bus.stall_o     = stall;
    assign bus.flush_o     = flush;
    assign bus.new_pc_o    = new_pc;
    assign bus.busy_o      = busy;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: exception, delay-slot, nested, interrupt
// priority, ERET, PC wrap and mid-sequence reset, with hand-computed writes.
module tb_cp0_exc_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   passed;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(
        input logic        ev,
        input logic [4:0]  code,
        input logic [31:0] pc,
        input logic        slot,
        input logic        eret,
        input logic        mwe,
        input logic [4:0]  maddr,
        input logic [31:0] mdata,
        input logic [31:0] status,
        input logic [31:0] cause,
        input logic [31:0] epc
    );
        bus.exc_valid_i     = ev;
        bus.exc_code_i      = code;
        bus.exc_pc_i        = pc;
        bus.in_delay_slot_i = slot;
        bus.eret_i          = eret;
        bus.mtc0_we_i       = mwe;
        bus.mtc0_addr_i     = maddr;
        bus.mtc0_data_i     = mdata;
        bus.status_i        = status;
        bus.cause_i         = cause;
        bus.epc_i           = epc;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
                      32'd0, 32'd0, 32'd0);
    endtask

    // Requests presented mid-sequence must all be ignored and snapshots must hold.
    task automatic applyGarbage();
        applyStimulus(1'b1, 5'd31, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b1, 5'd3,
                      32'h0000_DEAD, 32'd0, 32'hFFFF_FFFF, 32'h0000_BAD0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, obs, exp);
            $error("[TB] assertion on %s", name);
        end
    endtask

    task automatic expectAll(
        input string       tag,
        input logic [31:0] we,
        input logic [31:0] addr,
        input logic [31:0] data,
        input logic [31:0] stall,
        input logic [31:0] flush,
        input logic [31:0] newpc,
        input logic [31:0] busy
    );
        checkOutput({tag, ".we"},     32'(bus.cp0_we_o),    we);
        checkOutput({tag, ".waddr"},  32'(bus.cp0_waddr_o), addr);
        checkOutput({tag, ".wdata"},  bus.cp0_wdata_o,      data);
        checkOutput({tag, ".stall"},  32'(bus.stall_o),     stall);
        checkOutput({tag, ".flush"},  32'(bus.flush_o),     flush);
        checkOutput({tag, ".new_pc"}, bus.new_pc_o,         newpc);
        checkOutput({tag, ".busy"},   32'(bus.busy_o),      busy);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst    = 1'b0;
        applyIdle();
        expectAll("reset", 0, 0, 0, 0, 0, 0, 0);

        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd11, 32'd5,
                      32'd0, 32'd0, 32'd0);
        expectAll("mtc0_pass", 1, 11, 5, 0, 0, 0, 0);

        // Exception, EXL=0, not in slot; simultaneous MTC0 is dropped.
        nextCycle();
        applyStimulus(1'b1, 5'd8, 32'h100, 1'b0, 1'b0, 1'b1, 5'd9, 32'hAAAA,
                      32'h1000_0001, 32'h8000_0300, 32'd0);
        expectAll("exc_accept", 0, 0, 0, 1, 0, 0, 0);
        nextCycle();
        applyGarbage();
        expectAll("exc_epc", 1, 14, 32'h100, 1, 0, 0, 1);
        nextCycle();
        expectAll("exc_cause", 1, 13, 32'h0000_0320, 1, 0, 0, 1);
        nextCycle();
        expectAll("exc_status", 1, 12, 32'h1000_0003, 1, 0, 0, 1);
        nextCycle();
        applyIdle();
        expectAll("exc_redirect", 0, 0, 0, 1, 1, 32'h20, 1);
        nextCycle();
        expectAll("exc_done", 0, 0, 0, 0, 0, 0, 0);

        // Delay-slot exception with EXL=0.
        applyStimulus(1'b1, 5'd4, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,
                      32'h1, 32'd0, 32'd0);
        expectAll("slot_accept", 0, 0, 0, 1, 0, 0, 0);
        nextCycle();
        applyGarbage();
        expectAll("slot_epc", 1, 14, 32'h1FC, 1, 0, 0, 1);
        nextCycle();
        expectAll("slot_cause", 1, 13, 32'h8000_0010, 1, 0, 0, 1);
        nextCycle();
        expectAll("slot_status", 1, 12, 32'h3, 1, 0, 0, 1);
        nextCycle();
        applyIdle();
        expectAll("slot_redirect", 0, 0, 0, 1, 1, 32'h20, 1);
        nextCycle();
        expectAll("slot_done", 0, 0, 0, 0, 0, 0, 0);

        // Nested exception (EXL=1): EPC skipped, Cause[31] kept, flush one cycle sooner.
        applyStimulus(1'b1, 5'd10, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,
                      32'h3, 32'd0, 32'd0);
        expectAll("nest_accept", 0, 0, 0, 1, 0, 0, 0);
        nextCycle();
        applyGarbage();
        expectAll("nest_cause", 1, 13, 32'h28, 1, 0, 0, 1);
        nextCycle();
        expectAll("nest_status", 1, 12, 32'h3, 1, 0, 0, 1);
        nextCycle();
        applyIdle();
        expectAll("nest_redirect", 0, 0, 0, 1, 1, 32'h20, 1);
        nextCycle();
        expectAll("nest_done", 0, 0, 0, 0, 0, 0, 0);

        // Interrupt beats ERET and MTC0 in the same cycle.
        applyStimulus(1'b0, 5'd0, 32'h300, 1'b0, 1'b1, 1'b1, 5'd9, 32'h77,
                      32'h401, 32'h400, 32'h5555);
        expectAll("int_accept", 0, 0, 0, 1, 0, 0, 0);
        nextCycle();
        applyGarbage();
        expectAll("int_epc", 1, 14, 32'h300, 1, 0, 0, 1);
        nextCycle();
        expectAll("int_cause", 1, 13, 32'h400, 1, 0, 0, 1);
        nextCycle();
        expectAll("int_status", 1, 12, 32'h403, 1, 0, 0, 1);
        nextCycle();
        applyIdle();
        expectAll("int_redirect", 0, 0, 0, 1, 1, 32'h20, 1);
        nextCycle();
        expectAll("int_done", 0, 0, 0, 0, 0, 0, 0);

        // Interrupt masked by EXL: MTC0 passes straight through.
        applyStimulus(1'b0, 5'd0, 32'h300, 1'b0, 1'b0, 1'b1, 5'd9, 32'h77,
                      32'h403, 32'h400, 32'd0);
        expectAll("int_masked", 1, 9, 32'h77, 0, 0, 0, 0);

        // ERET.
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0,
                      32'h3, 32'd0, 32'h1234);
        expectAll("eret_accept", 0, 0, 0, 1, 0, 0, 0);
        nextCycle();
        applyGarbage();
        expectAll("eret_status", 1, 12, 32'h1, 1, 0, 0, 1);
        nextCycle();
        applyIdle();
        expectAll("eret_redirect", 0, 0, 0, 1, 1, 32'h1234, 1);
        nextCycle();
        expectAll("eret_done", 0, 0, 0, 0, 0, 0, 0);

        // Delay-slot PC of zero wraps.
        applyStimulus(1'b1, 5'd8, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,
                      32'h1, 32'd0, 32'd0);
        expectAll("wrap_accept", 0, 0, 0, 1, 0, 0, 0);
        nextCycle();
        applyGarbage();
        expectAll("wrap_epc", 1, 14, 32'hFFFF_FFFC, 1, 0, 0, 1);
        nextCycle();
        expectAll("wrap_cause", 1, 13, 32'h8000_0020, 1, 0, 0, 1);
        nextCycle();
        expectAll("wrap_status", 1, 12, 32'h3, 1, 0, 0, 1);
        nextCycle();
        applyIdle();
        expectAll("wrap_redirect", 0, 0, 0, 1, 1, 32'h20, 1);
        nextCycle();
        expectAll("wrap_done", 0, 0, 0, 0, 0, 0, 0);

        // Reset during W_CAUSE abandons the sequence.
        applyStimulus(1'b1, 5'd8, 32'h100, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
                      32'h1000_0001, 32'd0, 32'd0);
        expectAll("mid_accept", 0, 0, 0, 1, 0, 0, 0);
        nextCycle();
        applyGarbage();
        expectAll("mid_epc", 1, 14, 32'h100, 1, 0, 0, 1);
        nextCycle();
        expectAll("mid_cause", 1, 13, 32'h20, 1, 0, 0, 1);
        rst = 1'b0;
        #1;
        expectAll("mid_rst", 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        expectAll("mid_rst_hold", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd11, 32'd5,
                      32'd0, 32'd0, 32'd0);
        expectAll("mid_mtc0", 1, 11, 5, 0, 0, 0, 0);
        nextCycle();
        applyIdle();
        expectAll("mid_idle", 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
